// File: rtl/sim_uart_tx_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : sim_uart_tx_driver_if
// Description : Byte push handshake between a stimulus source and the
//               bench-side UART transmit driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface sim_uart_tx_driver_if;
  logic       wr_valid_i;
  logic [7:0] wr_data_i;
  logic       wr_ready_o;

  // Stimulus source side
  modport master (
    output wr_valid_i,
    output wr_data_i,
    input  wr_ready_o
  );

  // Driver side
  modport slave (
    input  wr_valid_i,
    input  wr_data_i,
    output wr_ready_o
  );
endinterface
`default_nettype wire

// File: rtl/sim_uart_tx_driver.sv
`default_nettype none
// ============================================================================
// Module      : sim_uart_tx_driver
// Description : Bench-side UART transmitter. Buffers pushed bytes in a FIFO
//               and serialises them 8N1/8N2 onto a registered, idle-high line.
//               Define SIM_UART_TX_PARITY_EN to insert an even parity bit
//               (8E1/8E2 frames).
// Revision    : 1.0 - initial release
// ============================================================================
module sim_uart_tx_driver #(
  parameter  int FREQ      = 500_000,
  parameter  int BAUD      = 7_200,
  parameter  int DEPTH     = 16,
  parameter  int STOP_BITS = 1,
  localparam int c_DEPTH_W = $clog2(DEPTH + 1)
) (
  input  wire logic                 clk_i,
  input  wire logic                 rst_ni,
  sim_uart_tx_driver_if.slave       wr_if,
  output logic                      tx_o,
  output logic                      busy_o,
  output logic [c_DEPTH_W-1:0]      fifo_depth_o,
  output logic [31:0]               frames_sent_o
);

  localparam int c_CLKS_PER_BIT = FREQ / BAUD;
  localparam int c_TMR_W        = (c_CLKS_PER_BIT > 2) ? $clog2(c_CLKS_PER_BIT) : 1;
  localparam int c_PTR_W        = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [c_TMR_W-1:0] c_TMR_LOAD = c_TMR_W'(c_CLKS_PER_BIT - 1);

  // Parameter sanity checks at elaboration
  if (c_CLKS_PER_BIT < 2) begin : g_err_clks_per_bit
    $error("sim_uart_tx_driver: FREQ/BAUD must be at least 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_err_stop_bits
    $error("sim_uart_tx_driver: STOP_BITS must be 1 or 2");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_err_depth
    $error("sim_uart_tx_driver: DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef SIM_UART_TX_PARITY_EN
    , ST_PARITY = 3'd4
`endif
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]           r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wptr;
  logic [c_PTR_W-1:0]   r_rptr;
  logic [c_DEPTH_W-1:0] r_count;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [7:0]           w_head;

  // Serialiser state
  state_t               r_state;
  logic [c_TMR_W-1:0]   r_timer;
  logic [2:0]           r_bit_idx;
  logic                 r_stop_idx;
  logic [7:0]           r_shift;
  logic                 r_tx;
  logic [31:0]          r_frames;
`ifdef SIM_UART_TX_PARITY_EN
  logic                 r_parity;
`endif
  logic                 w_bit_done;
  logic                 w_last_stop;

  // Full is judged on the registered occupancy only, so a same-cycle pop
  // never lets a full FIFO accept.
  assign w_full     = (r_count == c_DEPTH_W'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push     = wr_if.wr_valid_i & ~w_full;
  assign w_head     = r_mem[r_rptr];
  assign w_bit_done = (r_timer == '0);
  assign w_last_stop = (r_state == ST_STOP) && w_bit_done &&
                       (r_stop_idx == 1'(STOP_BITS - 1));
  // Head byte leaves the FIFO when a new frame starts: from idle, or
  // back-to-back at the end of the final stop bit.
  assign w_pop      = ~w_empty & ((r_state == ST_IDLE) | w_last_stop);

  assign wr_if.wr_ready_o = ~w_full;
  assign tx_o             = r_tx;
  assign busy_o           = (r_state != ST_IDLE) | ~w_empty;
  assign fifo_depth_o     = r_count;
  assign frames_sent_o    = r_frames;

  // FIFO data array write port
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= wr_if.wr_data_i;
    end
  end

  // FIFO pointers and occupancy; push and pop together leave occupancy alone
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_DEPTH_W'(1);
        2'b01:   r_count <= r_count - c_DEPTH_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame FSM; the line register follows the state one cycle behind
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_frames   <= '0;
`ifdef SIM_UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_state <= ST_START;
            r_timer <= c_TMR_LOAD;
            r_shift <= w_head;
`ifdef SIM_UART_TX_PARITY_EN
            r_parity <= ^w_head;
`endif
          end
        end

        ST_START: begin
          r_tx <= 1'b0;
          if (w_bit_done) begin
            r_state   <= ST_DATA;
            r_timer   <= c_TMR_LOAD;
            r_bit_idx <= '0;
          end else begin
            r_timer <= r_timer - c_TMR_W'(1);
          end
        end

        ST_DATA: begin
          r_tx <= r_shift[0];
          if (w_bit_done) begin
            r_timer <= c_TMR_LOAD;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
`ifdef SIM_UART_TX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
              r_stop_idx <= 1'b0;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_timer <= r_timer - c_TMR_W'(1);
          end
        end

`ifdef SIM_UART_TX_PARITY_EN
        ST_PARITY: begin
          r_tx <= r_parity;
          if (w_bit_done) begin
            r_state    <= ST_STOP;
            r_timer    <= c_TMR_LOAD;
            r_stop_idx <= 1'b0;
          end else begin
            r_timer <= r_timer - c_TMR_W'(1);
          end
        end
`endif

        ST_STOP: begin
          r_tx <= 1'b1;
          if (w_bit_done) begin
            r_timer <= c_TMR_LOAD;
            if (w_last_stop) begin
              r_frames <= r_frames + 32'd1;
              if (w_pop) begin
                r_state <= ST_START;
                r_shift <= w_head;
`ifdef SIM_UART_TX_PARITY_EN
                r_parity <= ^w_head;
`endif
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_stop_idx <= 1'b1;
            end
          end else begin
            r_timer <= r_timer - c_TMR_W'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sim_uart_tx_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_sim_uart_tx_driver
// Description : Scoreboard bench for sim_uart_tx_driver. Stimulus pushes
//               expected bytes into per-driver queues; line monitors decode
//               frames cycle by cycle and compare against the queue heads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sim_uart_tx_driver;

  localparam int FREQ  = 80;
  localparam int BAUD  = 10;
  localparam int CPB   = 8;
  localparam int DEPTH = 16;
  localparam int DW    = 5;
`ifdef SIM_UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME0 = (10 + PAR) * CPB;
  localparam int FRAME1 = (11 + PAR) * CPB;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  sim_uart_tx_driver_if bus0();
  sim_uart_tx_driver_if bus1();

  logic          tx0, busy0, tx1, busy1;
  logic [DW-1:0] depth0, depth1;
  logic [31:0]   frames0, frames1;

  sim_uart_tx_driver #(.FREQ(FREQ), .BAUD(BAUD), .DEPTH(DEPTH), .STOP_BITS(1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .wr_if(bus0), .tx_o(tx0), .busy_o(busy0),
    .fifo_depth_o(depth0), .frames_sent_o(frames0)
  );

  sim_uart_tx_driver #(.FREQ(FREQ), .BAUD(BAUD), .DEPTH(DEPTH), .STOP_BITS(2)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .wr_if(bus1), .tx_o(tx1), .busy_o(busy1),
    .fifo_depth_o(depth1), .frames_sent_o(frames1)
  );

  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  int          starts0[$];
  int          last_start[2];
  int          last_end[2];
  logic [31:0] mon_frames[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic get_tx(input int id);
    return (id == 0) ? tx0 : tx1;
  endfunction
  function automatic logic get_busy(input int id);
    return (id == 0) ? busy0 : busy1;
  endfunction
  function automatic logic get_ready(input int id);
    return (id == 0) ? bus0.wr_ready_o : bus1.wr_ready_o;
  endfunction
  function automatic logic [31:0] get_frames(input int id);
    return (id == 0) ? frames0 : frames1;
  endfunction

  // Expected line levels, bit 0 = start bit; stop bits default to 1
  function automatic logic [11:0] frame_vec(input logic [7:0] d);
    logic [11:0] v;
    v      = '1;
    v[0]   = 1'b0;
    v[8:1] = d;
`ifdef SIM_UART_TX_PARITY_EN
    v[9]   = ^d;
`endif
    return v;
  endfunction

  task automatic set_wr(input int id, input logic v, input logic [7:0] d);
    if (id == 0) begin
      bus0.wr_valid_i = v;
      bus0.wr_data_i  = d;
    end else begin
      bus1.wr_valid_i = v;
      bus1.wr_data_i  = d;
    end
  endtask

  task automatic qpush(input int id, input logic [7:0] d);
    if (id == 0) q0.push_back(d);
    else         q1.push_back(d);
  endtask

  // Line monitor: decodes one frame per falling edge, cycle by cycle
  task automatic run_mon(input int id);
    logic [7:0]  d;
    logic [11:0] v;
    int          nb;
    logic        have, bad, aborted;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_frames[id] = 0;
        continue;
      end
      if (get_tx(id) == 1'b0) begin
        last_start[id] = cyc;
        if (id == 0) starts0.push_back(cyc);
        have = 1'b0;
        d    = 8'h00;
        if (id == 0 && q0.size() > 0) begin d = q0.pop_front(); have = 1'b1; end
        if (id == 1 && q1.size() > 0) begin d = q1.pop_front(); have = 1'b1; end
        if (!have) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame dut%0d: got start bit, expected idle", id);
          for (int k = 0; k < 400 && get_tx(id) == 1'b0; k++) @(negedge clk);
          continue;
        end
        v       = frame_vec(d);
        nb      = (id == 0) ? (10 + PAR) : (11 + PAR);
        aborted = 1'b0;
        for (int b = 0; b < nb && !aborted; b++) begin
          bad = 1'b0;
          for (int c = 0; c < CPB; c++) begin
            if (b != 0 || c != 0) begin
              @(negedge clk);
              if (!rst_n) begin
                aborted = 1'b1;
                break;
              end
            end
            if (get_tx(id) !== v[b]) bad = 1'b1;
            if (b == nb - 1 && c == CPB - 2)
              check($sformatf("frames_before_end dut%0d", id), get_frames(id), mon_frames[id]);
            if (b == nb - 1 && c == CPB - 1)
              check($sformatf("frames_at_end dut%0d", id), get_frames(id), mon_frames[id] + 1);
          end
          if (!aborted) begin
            checks++;
            if (bad) begin
              errors++;
              $display("FAIL line_bit dut%0d byte %02h bit %0d: got wrong level, expected %0b",
                       id, d, b, v[b]);
            end
          end
        end
        if (aborted) begin
          mon_frames[id] = 0;
        end else begin
          mon_frames[id] = mon_frames[id] + 1;
          last_end[id]   = cyc;
        end
      end
    end
  endtask

  initial run_mon(0);
  initial run_mon(1);

  // Push one byte; returns the accepting clock edge number
  task automatic push(input int id, input logic [7:0] d, output int acc);
    logic got;
    got = 1'b0;
    acc = -1;
    set_wr(id, 1'b1, d);
    for (int k = 0; k < 2000; k++) begin
      if (get_ready(id)) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (got) begin
      qpush(id, d);
      acc = cyc + 1;
      @(negedge clk);
    end else begin
      check("push_ready_timeout", 32'd0, 32'd1);
    end
    set_wr(id, 1'b0, 8'h00);
  endtask

  task automatic wait_idle(input int id);
    for (int k = 0; k < 4000 && get_busy(id); k++) @(negedge clk);
    check($sformatf("idle_wait dut%0d", id), {31'd0, get_busy(id)}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, tmp, acc;
    logic bad;
    mon_frames[0] = 0;
    mon_frames[1] = 0;
    last_start[0] = 0; last_start[1] = 0;
    last_end[0] = 0;   last_end[1] = 0;
    set_wr(0, 1'b0, 8'h00);
    set_wr(1, 1'b0, 8'h00);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_tx",     {31'd0, tx0},             32'd1);
    check("rst_ready",  {31'd0, bus0.wr_ready_o}, 32'd1);
    check("rst_busy",   {31'd0, busy0},           32'd0);
    check("rst_depth",  {27'd0, depth0},          32'd0);
    check("rst_frames", frames0,                  32'd0);
    check("rst_tx1",    {31'd0, tx1},             32'd1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte, latency and frame length
    starts0.delete();
    push(0, 8'hA5, n);
    wait_idle(0);
    check("t1_latency", starts0.size() > 0 ? starts0[0] : -1, n + 2);
    check("t1_len", last_end[0] - last_start[0] + 1, FRAME0);
    check("t1_frames", frames0, 32'd1);
    check("t1_busy", {31'd0, busy0}, 32'd0);

    // Three back-to-back frames
    starts0.delete();
    push(0, 8'h00, n);
    push(0, 8'hFF, tmp);
    push(0, 8'h55, tmp);
    wait_idle(0);
    check("t2_nframes", starts0.size(), 3);
    check("t2_gap01", starts0.size() >= 3 ? starts0[1] - starts0[0] : -1, FRAME0);
    check("t2_gap12", starts0.size() >= 3 ? starts0[2] - starts0[1] : -1, FRAME0);
    check("t2_frames", frames0, 32'd4);

    // Hold valid until the FIFO fills
    acc = 0;
    bus0.wr_valid_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus0.wr_data_i = 8'h30 + 8'(acc);
      if (!bus0.wr_ready_o) break;
      q0.push_back(bus0.wr_data_i);
      acc++;
      @(negedge clk);
    end
    check("t3_accepted", acc, 17);
    check("t3_depth_full", {27'd0, depth0}, 32'd16);
    bus0.wr_data_i = 8'hEE;
    for (int k = 0; k < 200 && depth0 == 5'd16; k++) @(negedge clk);
    bus0.wr_valid_i = 1'b0;
    check("t3_refused_on_pop", {27'd0, depth0}, 32'd15);
    wait_idle(0);
    check("t3_frames", frames0, 32'd21);
    check("t3_queue_drained", q0.size(), 0);

    // Reset in the middle of data bit 3 with four bytes queued
    push(0, 8'h5A, n);
    push(0, 8'h11, tmp);
    push(0, 8'h22, tmp);
    push(0, 8'h33, tmp);
    push(0, 8'h44, tmp);
    for (int k = 0; k < 500 && cyc != n + 2 + 8 + 24 + 4; k++) @(negedge clk);
    check("t4_depth_before", {27'd0, depth0}, 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_tx_async", {31'd0, tx0}, 32'd1);
    check("t4_depth", {27'd0, depth0}, 32'd0);
    check("t4_frames", frames0, 32'd0);
    check("t4_busy", {31'd0, busy0}, 32'd0);
    q0.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (tx0 !== 1'b1) bad = 1'b1;
    end
    check("t4_idle_after_release", {31'd0, bad}, 32'd0);
    push(0, 8'h81, n);
    wait_idle(0);
    check("t4_recover_frames", frames0, 32'd1);

    // Two stop bits
    push(1, 8'h3C, n);
    wait_idle(1);
    check("t5_len", last_end[1] - last_start[1] + 1, FRAME1);
    check("t5_latency", last_start[1], n + 2);
    check("t5_frames", frames1, 32'd1);

    // Parity stimulus (frame length depends on build)
    starts0.delete();
    push(0, 8'h07, n);
    push(0, 8'h03, tmp);
    wait_idle(0);
    check("t6_gap", starts0.size() >= 2 ? starts0[1] - starts0[0] : -1, FRAME0);
    check("t6_len", last_end[0] - last_start[0] + 1, FRAME0);
    check("t6_frames", frames0, 32'd3);

    check("final_q0_empty", q0.size(), 0);
    check("final_q1_empty", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
